// File: rtl/shift_seq_unit.sv
// Multi-cycle sequential shifter: one bit position per clock, valid/ready on both sides.
// Supports SHL, logical SHR, arithmetic SSHR and signed-amount BIDIR with a sticky shifted-out flag.
module shift_seq_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        OP_SHL   = 2'b00,
        OP_SHR   = 2'b01,
        OP_SSHR  = 2'b10,
        OP_BIDIR = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sticky_q, sticky_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic             ready_q, ready_d;

    logic [AMT_W:0]   mag;
    logic [CNT_W-1:0] count_load;
    logic             amt_neg;
    logic             accept;

    // BIDIR amounts are two's complement; one extra bit keeps the most negative value representable.
    always_comb begin
        amt_neg = (op_e'(in_op) == OP_BIDIR) && in_amt[AMT_W-1];
        mag     = {1'b0, in_amt};
        if (amt_neg) begin
            mag = -{in_amt[AMT_W-1], in_amt};
        end
        if (32'(mag) >= 32'(WIDTH)) begin
            count_load = CNT_W'(WIDTH);
        end else begin
            count_load = CNT_W'(mag);
        end
    end

    assign accept = in_valid && ready_q;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        data_d   = data_q;
        sticky_d = sticky_q;
        left_d   = left_q;
        arith_d  = arith_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d   = in_data;
                    sticky_d = 1'b0;
                    left_d   = (op_e'(in_op) == OP_SHL) || amt_neg;
                    arith_d  = (op_e'(in_op) == OP_SSHR) ||
                               ((op_e'(in_op) == OP_BIDIR) && !amt_neg);
                    count_d  = count_load;
                    state_d  = (count_load == '0) ? DONE : SHIFT;
                end
            end

            SHIFT: begin
                if (count_q != '0) begin
                    if (left_q) begin
                        sticky_d = sticky_q | data_q[WIDTH-1];
                        data_d   = {data_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sticky_d = sticky_q | data_q[0];
                        data_d   = {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    end
                    count_d = count_q - CNT_W'(1);
                end
                if (count_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Registered ready stays low through reset and rises on the first edge after release.
    assign ready_d = (state_d == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            data_q   <= '0;
            sticky_q <= 1'b0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_q   <= data_d;
            sticky_q <= sticky_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
            ready_q  <= ready_d;
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = (state_q == DONE);
    assign out_data   = data_q;
    assign out_sticky = sticky_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed plan cases, backpressure, reset
// mid-operation, back-to-back and randomized traffic against an arithmetic reference model.
module tb_shift_seq_unit;

    localparam int W  = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_op = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_sticky;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] d;
        logic [4:0] a;
        logic [1:0] op;
        logic [7:0] ed;
        logic       es;
        int         el;
    } vec_t;

    always #5 clk = ~clk;

    shift_seq_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    // Reference: whole-word shifts on 64-bit integers; latency equals the saturated amount.
    function automatic void model(input logic [7:0] d, input logic [4:0] a, input logic [1:0] op,
                                  output logic [7:0] res, output logic sticky, output int n);
        int              mag;
        bit              left;
        bit              arith;
        longint          sd;
        longint unsigned full;
        longint unsigned lowmask;
        left  = 1'b0;
        arith = 1'b0;
        mag   = int'(a);
        case (op)
            2'b00: left = 1'b1;
            2'b10: arith = 1'b1;
            2'b11: begin
                mag = a[4] ? int'(a) - 32 : int'(a);
                if (mag < 0) begin
                    left = 1'b1;
                    mag  = -mag;
                end else begin
                    arith = 1'b1;
                end
            end
            default: ;
        endcase
        n = (mag > W) ? W : mag;
        if (left) begin
            full   = longint'(d) << mag;
            res    = full[7:0];
            sticky = (full >> W) != 0;
        end else begin
            sd      = (arith && d[7]) ? longint'(d) - 256 : longint'(d);
            sd      = sd >>> mag;
            res     = sd[7:0];
            lowmask = (64'd1 << n) - 64'd1;
            sticky  = (longint'(d) & lowmask) != 0;
        end
    endfunction

    // Drives one request, waits for the result with bounded loops, then takes it.
    task automatic send(input logic [7:0] d, input logic [4:0] a, input logic [1:0] op,
                        input int hold, output int lat, output logic [7:0] rd,
                        output logic rs, output bit ok);
        int guard;
        ok    = 1'b1;
        lat   = 0;
        rd    = '0;
        rs    = 1'b0;
        guard = 0;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            ok       = 1'b0;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_amt   = 5'($urandom);
        in_op    = 2'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            ok = 1'b0;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rd        = out_data;
        rs        = out_sticky;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_amt   = 5'd3;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else passed++;
        total++; if (out_sticky !== 1'b0) $display("FAIL reset_out_sticky: got %b want 0", out_sticky); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_held: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid); else passed++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_directed();
        vec_t       vecs[10];
        int         lat;
        logic [7:0] rd;
        logic       rs;
        bit         ok;
        vecs = '{
            '{8'h81, 5'd3,     2'b00, 8'h08, 1'b1, 3},
            '{8'h90, 5'd2,     2'b10, 8'hE4, 1'b0, 2},
            '{8'h90, 5'd31,    2'b10, 8'hFF, 1'b1, 8},
            '{8'h90, 5'd20,    2'b01, 8'h00, 1'b1, 8},
            '{8'h41, 5'b11110, 2'b11, 8'h04, 1'b1, 2},
            '{8'h81, 5'd1,     2'b11, 8'hC0, 1'b1, 1},
            '{8'h5A, 5'b10000, 2'b11, 8'h00, 1'b1, 8},
            '{8'hA5, 5'd8,     2'b00, 8'h00, 1'b1, 8},
            '{8'h3C, 5'd0,     2'b00, 8'h3C, 1'b0, 0},
            '{8'h7E, 5'd7,     2'b10, 8'h00, 1'b1, 7}
        };
        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].a, vecs[i].op, i % 3, lat, rd, rs, ok);
            total++; if (!ok) $display("FAIL directed_%0d_timeout: handshake did not complete", i); else passed++;
            total++; if (rd !== vecs[i].ed) $display("FAIL directed_%0d_data: got %h want %h", i, rd, vecs[i].ed); else passed++;
            total++; if (rs !== vecs[i].es) $display("FAIL directed_%0d_sticky: got %b want %b", i, rs, vecs[i].es); else passed++;
            total++; if (lat != vecs[i].el) $display("FAIL directed_%0d_latency: got %0d want %0d", i, lat, vecs[i].el); else passed++;
        end
    endtask

    task automatic test_backpressure();
        in_data  = 8'h5A;
        in_amt   = 5'd0;
        in_op    = 2'b01;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_before: got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_data = 8'hFF;
        in_amt  = 5'd3;
        in_op   = 2'b00;
        total++; if (out_valid !== 1'b1) $display("FAIL bp_valid_next: got %b want 1", out_valid); else passed++;
        total++; if (out_data !== 8'h5A || out_sticky !== 1'b0)
            $display("FAIL bp_result: got %h/%b want 5a/0", out_data, out_sticky); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_sticky !== 1'b0)
                $display("FAIL bp_hold_%0d: got valid=%b data=%h sticky=%b want 1/5a/0", c, out_valid, out_data, out_sticky);
                else passed++;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_hold_%0d: got %b want 0", c, in_ready); else passed++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_rise: got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h5A)
            $display("FAIL bp_no_ghost: got valid=%b data=%h want 0/5a", out_valid, out_data); else passed++;
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        in_data  = 8'hFF;
        in_amt   = 5'd7;
        in_op    = 2'b00;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL midrst_data: got %h want 00", out_data); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", in_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready_after: got %b want 1", in_ready); else passed++;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL midrst_stale: got out_valid=%b want 0", seen); else passed++;
    endtask

    task automatic run_random(input string tag, input int iters, input bit with_hold);
        logic [7:0] d;
        logic [4:0] a;
        logic [1:0] op;
        logic [7:0] rd;
        logic [7:0] ed;
        logic       rs;
        logic       es;
        int         lat;
        int         el;
        bit         ok;
        for (int i = 0; i < iters; i++) begin
            d  = 8'($urandom);
            a  = 5'($urandom);
            op = 2'($urandom);
            model(d, a, op, ed, es, el);
            send(d, a, op, with_hold ? int'($urandom_range(0, 2)) : 0, lat, rd, rs, ok);
            total++; if (!ok) $display("FAIL %s_%0d_timeout: d=%h a=%h op=%0d", tag, i, d, a, op); else passed++;
            total++; if (rd !== ed) $display("FAIL %s_%0d_data: d=%h a=%h op=%0d got %h want %h", tag, i, d, a, op, rd, ed); else passed++;
            total++; if (rs !== es) $display("FAIL %s_%0d_sticky: d=%h a=%h op=%0d got %b want %b", tag, i, d, a, op, rs, es); else passed++;
            total++; if (lat != el) $display("FAIL %s_%0d_latency: d=%h a=%h op=%0d got %0d want %0d", tag, i, d, a, op, lat, el); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        run_random("b2b", 6, 1'b0);
    endtask

    task automatic test_random();
        run_random("rand", 40, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
